iec_bus_hub: RTL and testbench

- Multi-device IEC serial-bus hub for the drive subsystem. It replaces per-drive ad-hoc synchronisers and wired-AND terms.
- Forms the open-collector bus from one host and NUM_DEV drive channels.
- Applies hardware ATN-acknowledge per drive and provides per-line stability filtering of programmable length.
- Generates shared phi2 rising/falling enables and a bus-idle indication. Every drive core and the host interface take their filtered bus view and phase enables from here.

---
 rtl/iec_bus_hub.sv | 199 +++++++++++++++++++
 tb/tb_iec_bus_hub.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/iec_bus_hub.sv
// IEC serial-bus hub: wired-AND bus, per-line stability filters, phi2 enables and idle detect.
// Optional bus-trace FIFO enabled by defining IEC_SNOOP_EN.
module iec_bus_hub #(
    parameter int NUM_DEV    = 4,
    parameter int FILTER_LEN = 2,
    parameter int CLK_DIV    = 32,
    parameter int IDLE_CYC   = 1000
) (
    input  logic               clk32,
    input  logic               reset_n,
    input  logic               host_atn_o,
    input  logic               host_clk_o,
    input  logic               host_data_o,
    input  logic [NUM_DEV-1:0] dev_en,
    input  logic [NUM_DEV-1:0] dev_clk_o,
    input  logic [NUM_DEV-1:0] dev_data_o,
    input  logic [NUM_DEV-1:0] dev_atna,
    output logic               bus_atn,
    output logic               bus_clk,
    output logic               bus_data,
    output logic               filt_atn,
    output logic               filt_clk,
    output logic               filt_data,
    output logic               atn_fall,
    output logic               p2_r,
    output logic               p2_f,
    output logic               idle
`ifdef IEC_SNOOP_EN
    ,
    input  logic               snoop_rd,
    output logic [18:0]        snoop_q,
    output logic               snoop_empty,
    output logic               snoop_ovf
`endif
);

    localparam int              DIV_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [3:0]      FILT_LAST = 4'(FILTER_LEN - 1);
    localparam logic [15:0]     IDLE_MAX  = 16'(IDLE_CYC);

    logic [NUM_DEV-1:0] eff_clk_s;
    logic [NUM_DEV-1:0] eff_data_s;
    logic [2:0]         bus_vec_s;
    logic [2:0]         filt_r;
    logic [2:0]         filt_nx_s;
    logic [3:0]         fcnt_r  [3];
    logic [3:0]         fcnt_nx_s [3];
    logic               atn_prev_r;
    logic [DIV_W-1:0]   div_cnt_r;
    logic [15:0]        idle_cnt_r;
    logic [15:0]        idle_cnt_nx_s;
    logic               idle_nx_s;

    // Per-channel contributions; a drive answers ATN by pulling DATA when ATNA disagrees with it.
    always_comb begin
        eff_clk_s  = dev_clk_o | ~dev_en;
        eff_data_s = ~dev_en | (dev_data_o & ~(dev_atna ^ {NUM_DEV{~host_atn_o}}));
    end

    // Raw wired-AND bus register.
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            bus_atn  <= 1'b1;
            bus_clk  <= 1'b1;
            bus_data <= 1'b1;
        end else begin
            bus_atn  <= host_atn_o;
            bus_clk  <= host_clk_o & (&eff_clk_s);
            bus_data <= host_data_o & (&eff_data_s);
        end
    end

    assign bus_vec_s = {bus_atn, bus_clk, bus_data};

    // Filter next-state: index 2=ATN, 1=CLK, 0=DATA.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            filt_nx_s[i] = filt_r[i];
            fcnt_nx_s[i] = 4'd0;
            if (bus_vec_s[i] == filt_r[i]) begin
                fcnt_nx_s[i] = 4'd0;
            end else if (fcnt_r[i] == FILT_LAST) begin
                filt_nx_s[i] = bus_vec_s[i];
                fcnt_nx_s[i] = 4'd0;
            end else begin
                fcnt_nx_s[i] = fcnt_r[i] + 4'd1;
            end
        end
    end

    // Filter state and ATN falling-edge detect.
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            filt_r     <= 3'b111;
            atn_prev_r <= 1'b1;
            atn_fall   <= 1'b0;
            for (int i = 0; i < 3; i++) fcnt_r[i] <= 4'd0;
        end else begin
            filt_r     <= filt_nx_s;
            atn_prev_r <= filt_r[2];
            atn_fall   <= atn_prev_r & ~filt_r[2];
            for (int i = 0; i < 3; i++) fcnt_r[i] <= fcnt_nx_s[i];
        end
    end

    assign filt_atn  = filt_r[2];
    assign filt_clk  = filt_r[1];
    assign filt_data = filt_r[0];

    // Free-running phi2 divider with registered phase enables.
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_r <= '0;
            p2_r      <= 1'b0;
            p2_f      <= 1'b0;
        end else begin
            p2_r      <= (div_cnt_r == '0);
            p2_f      <= (div_cnt_r == DIV_HALF);
            div_cnt_r <= (div_cnt_r == DIV_LAST) ? '0 : div_cnt_r + 1'b1;
        end
    end

    // Idle counter next-state; any filtered line low restarts the quiet interval.
    always_comb begin
        if (filt_r != 3'b111) begin
            idle_cnt_nx_s = 16'd0;
        end else if (idle_cnt_r == IDLE_MAX) begin
            idle_cnt_nx_s = idle_cnt_r;
        end else begin
            idle_cnt_nx_s = idle_cnt_r + 16'd1;
        end
        idle_nx_s = (idle_cnt_nx_s == IDLE_MAX);
    end

    // Idle counter and flag register.
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt_r <= 16'd0;
            idle       <= 1'b0;
        end else begin
            idle_cnt_r <= idle_cnt_nx_s;
            idle       <= idle_nx_s;
        end
    end

`ifdef IEC_SNOOP_EN
    logic [15:0] ts_r;
    logic [18:0] fifo_r [4];
    logic [1:0]  wptr_r;
    logic [1:0]  rptr_r;
    logic [2:0]  fcount_r;
    logic        wr_s;
    logic        pop_s;
    logic        full_s;
    logic        wr_ok_s;

    always_comb begin
        wr_s    = (filt_nx_s != filt_r);
        pop_s   = snoop_rd & (fcount_r != 3'd0);
        full_s  = (fcount_r == 3'd4);
        wr_ok_s = wr_s & (~full_s | pop_s);
    end

    // Trace FIFO: the word carries the timestamp of the commit edge and the newly committed lines.
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            ts_r      <= 16'd0;
            wptr_r    <= 2'd0;
            rptr_r    <= 2'd0;
            fcount_r  <= 3'd0;
            snoop_ovf <= 1'b0;
            for (int i = 0; i < 4; i++) fifo_r[i] <= 19'd0;
        end else begin
            ts_r <= ts_r + 16'd1;
            if (wr_ok_s) begin
                fifo_r[wptr_r] <= {ts_r, filt_nx_s};
                wptr_r         <= wptr_r + 2'd1;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + 2'd1;
            end
            case ({wr_ok_s, pop_s})
                2'b10:   fcount_r <= fcount_r + 3'd1;
                2'b01:   fcount_r <= fcount_r - 3'd1;
                default: fcount_r <= fcount_r;
            endcase
            if (wr_s && full_s && !pop_s) begin
                snoop_ovf <= 1'b1;
            end
        end
    end

    assign snoop_q     = fifo_r[rptr_r];
    assign snoop_empty = (fcount_r == 3'd0);
`endif

endmodule

// File: tb/tb_iec_bus_hub.sv
// Directed bench for iec_bus_hub: raw-bus vector table plus hand sequences for filter, phase and idle timing.
module tb_iec_bus_hub;

    logic       clk32 = 1'b0;
    logic       reset_n;
    logic       host_atn_o, host_clk_o, host_data_o;
    logic [3:0] dev_en, dev_clk_o, dev_data_o, dev_atna;
    logic       bus_atn, bus_clk, bus_data;
    logic       filt_atn, filt_clk, filt_data;
    logic       atn_fall, p2_r, p2_f, idle;
`ifdef IEC_SNOOP_EN
    logic        snoop_rd;
    logic [18:0] snoop_q;
    logic        snoop_empty;
    logic        snoop_ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    iec_bus_hub #(.NUM_DEV(4), .FILTER_LEN(2), .CLK_DIV(32), .IDLE_CYC(1000)) dut (
        .clk32(clk32), .reset_n(reset_n),
        .host_atn_o(host_atn_o), .host_clk_o(host_clk_o), .host_data_o(host_data_o),
        .dev_en(dev_en), .dev_clk_o(dev_clk_o), .dev_data_o(dev_data_o), .dev_atna(dev_atna),
        .bus_atn(bus_atn), .bus_clk(bus_clk), .bus_data(bus_data),
        .filt_atn(filt_atn), .filt_clk(filt_clk), .filt_data(filt_data),
        .atn_fall(atn_fall), .p2_r(p2_r), .p2_f(p2_f), .idle(idle)
`ifdef IEC_SNOOP_EN
        , .snoop_rd(snoop_rd), .snoop_q(snoop_q), .snoop_empty(snoop_empty), .snoop_ovf(snoop_ovf)
`endif
    );

    always #5 clk32 = ~clk32;

    typedef struct packed {
        logic       ha, hc, hd;
        logic [3:0] en, dc, dd, da;
        logic       ea, ec, ed;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk32);
        @(negedge clk32);
    endtask

    task automatic quiet();
        host_atn_o = 1'b1; host_clk_o = 1'b1; host_data_o = 1'b1;
        dev_en = 4'hF; dev_clk_o = 4'hF; dev_data_o = 4'hF; dev_atna = 4'h0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk32);
        reset_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 4'hF, 4'hE, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 4'hE, 4'hE, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 4'hB, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 4'hB, 4'hF, 4'hF, 4'hB, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 4'h4, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'h7, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 4'h7, 4'h7, 4'h7, 4'h8, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};

        quiet();
`ifdef IEC_SNOOP_EN
        snoop_rd = 1'b0;
`endif
        reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_bus", {29'd0, bus_atn, bus_clk, bus_data}, 32'h7);
        chk("rst_filt", {29'd0, filt_atn, filt_clk, filt_data}, 32'h7);
        chk("rst_pulses", {28'd0, atn_fall, p2_r, p2_f, idle}, 32'h0);
        reset_n = 1'b1;

        // Phase enables, quiet filters and idle rise from reset release.
        for (int e = 1; e <= 1005; e++) begin
            tick();
            chk("p2_r", {31'd0, p2_r}, {31'd0, (e % 32) == 1});
            chk("p2_f", {31'd0, p2_f}, {31'd0, (e % 32) == 17});
            chk("idle_rise", {31'd0, idle}, {31'd0, e >= 1000});
            chk("quiet_filt", {29'd0, filt_atn, filt_clk, filt_data}, 32'h7);
        end

        // One-cycle DATA glitch is rejected.
        host_data_o = 1'b0;
        tick();
        chk("glitch_bus_low", {31'd0, bus_data}, 32'd0);
        host_data_o = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("glitch_bus_high", {31'd0, bus_data}, 32'd1);
            chk("glitch_filt", {31'd0, filt_data}, 32'd1);
            chk("glitch_idle", {31'd0, idle}, 32'd1);
        end

        // Raw wired-AND vectors.
        for (int v = 0; v < 12; v++) begin
            host_atn_o = vecs[v].ha; host_clk_o = vecs[v].hc; host_data_o = vecs[v].hd;
            dev_en = vecs[v].en; dev_clk_o = vecs[v].dc; dev_data_o = vecs[v].dd; dev_atna = vecs[v].da;
            tick();
            chk($sformatf("vec%0d_bus", v), {29'd0, bus_atn, bus_clk, bus_data},
                {29'd0, vecs[v].ea, vecs[v].ec, vecs[v].ed});
        end

        // Asynchronous reset while all lines are low.
        reset_n = 1'b0;
        #2;
        chk("async_rst_bus", {29'd0, bus_atn, bus_clk, bus_data}, 32'h7);
        quiet();
        @(negedge clk32);
        reset_n = 1'b1;
        repeat (1001) tick();
        chk("idle_before_atn", {31'd0, idle}, 32'd1);

        // ATN assertion: filter latency, atn_fall pulse and idle drop.
        host_atn_o = 1'b0;
        dev_atna   = 4'hF;
        tick();
        chk("atn_e1_bus", {31'd0, bus_atn}, 32'd0);
        chk("atn_e1_filt", {31'd0, filt_atn}, 32'd1);
        chk("atn_e1_fall", {31'd0, atn_fall}, 32'd0);
        tick();
        chk("atn_e2_filt", {31'd0, filt_atn}, 32'd1);
        tick();
        chk("atn_e3_filt", {31'd0, filt_atn}, 32'd0);
        chk("atn_e3_fall", {31'd0, atn_fall}, 32'd0);
        chk("atn_e3_idle", {31'd0, idle}, 32'd1);
        tick();
        chk("atn_e4_fall", {31'd0, atn_fall}, 32'd1);
        chk("atn_e4_idle", {31'd0, idle}, 32'd0);
        chk("atn_e4_other", {30'd0, filt_clk, filt_data}, 32'h3);
        tick();
        chk("atn_e5_fall", {31'd0, atn_fall}, 32'd0);
        chk("atn_e5_filt", {31'd0, filt_atn}, 32'd0);

        // Auto-acknowledge from channel 2, then channel 2 removed.
        dev_atna = 4'hB;
        tick();
        chk("ack_bus_data", {31'd0, bus_data}, 32'd0);
        dev_en = 4'hB;
        tick();
        chk("ack_disabled", {31'd0, bus_data}, 32'd1);

`ifdef IEC_SNOOP_EN
        begin
            int e;
            logic [15:0] exp_ts [5];
            quiet();
            do_reset();
            e = 0;
            for (int k = 0; k < 5; k++) begin
                host_clk_o = (k % 2) == 1;
                exp_ts[k] = 16'(e + 2);
                for (int t = 0; t < 6; t++) begin
                    tick();
                    e++;
                end
            end
            chk("snoop_ovf", {31'd0, snoop_ovf}, 32'd1);
            for (int k = 0; k < 4; k++) begin
                chk("snoop_not_empty", {31'd0, snoop_empty}, 32'd0);
                chk("snoop_ts", {16'd0, snoop_q[18:3]}, {16'd0, exp_ts[k]});
                chk("snoop_clk", {31'd0, snoop_q[1]}, {31'd0, (k % 2) == 1});
                snoop_rd = 1'b1;
                tick();
                snoop_rd = 1'b0;
            end
            chk("snoop_empty", {31'd0, snoop_empty}, 32'd1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
